// File: rtl/xcfi_mem_arbiter.sv
// Two-requester (imem/dmem) arbiter onto one memory port, with an in-order id FIFO for routing responses.
// Define XCFI_ARB_ROUND_ROBIN_EN for last-grant round-robin; otherwise dmem has fixed priority.
module xcfi_mem_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        rq_req,
  input  logic [1:0]        rq_wen,
  input  logic [7:0]        rq_strb,
  input  logic [2*XLEN-1:0] rq_wdata,
  input  logic [2*XLEN-1:0] rq_addr,
  output logic [1:0]        rq_gnt,
  output logic [1:0]        rq_recv,
  input  logic [1:0]        rq_ack,
  output logic              rq_error,
  output logic [XLEN-1:0]   rq_rdata,
  output logic              m_req,
  output logic              m_wen,
  output logic [3:0]        m_strb,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN-1:0]   m_addr,
  input  logic              m_gnt,
  input  logic              m_recv,
  input  logic              m_error,
  input  logic [XLEN-1:0]   m_rdata,
  output logic              m_ack
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic          lock_reg, lock_next;
  logic          lock_id_reg, lock_id_next;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          id_mem [DEPTH];

  logic winner;
  logic sel;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_id;

`ifdef XCFI_ARB_ROUND_ROBIN_EN
  logic last_gnt_reg;

  // On contention, favour whoever did not win the previous accepted request.
  always_comb begin
    winner = rq_req[1];
    if (rq_req == 2'b11) begin
      winner = ~last_gnt_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt_reg <= 1'b1;
    end else if (push) begin
      last_gnt_reg <= sel;
    end
  end
`else
  always_comb begin
    winner = rq_req[1];
  end
`endif

  assign sel   = lock_reg ? lock_id_reg : winner;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // Request path is purely combinational from the selected requester.
  assign m_req   = ~reset & rq_req[sel] & ~full;
  assign m_wen   = rq_wen[sel];
  assign m_strb  = sel ? rq_strb[7:4] : rq_strb[3:0];
  assign m_wdata = sel ? rq_wdata[2*XLEN-1:XLEN] : rq_wdata[XLEN-1:0];
  assign m_addr  = sel ? rq_addr[2*XLEN-1:XLEN] : rq_addr[XLEN-1:0];
  assign push    = m_req & m_gnt;

  assign head_id  = id_mem[rd_ptr_reg];
  assign m_ack    = ~reset & ~empty & rq_ack[head_id];
  assign pop      = m_recv & m_ack;
  assign rq_rdata = m_rdata;
  assign rq_error = m_error;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign rq_gnt[gi]  = push & (sel == 1'(gi));
      assign rq_recv[gi] = ~reset & ~empty & m_recv & (head_id == 1'(gi));
    end
  endgenerate

  // A stalled request keeps its requester selected until accepted or withdrawn.
  always_comb begin
    lock_next    = lock_reg;
    lock_id_next = lock_id_reg;
    if (push) begin
      lock_next = 1'b0;
    end else if (m_req) begin
      lock_next    = 1'b1;
      lock_id_next = sel;
    end else if (lock_reg && !rq_req[lock_id_reg]) begin
      lock_next = 1'b0;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_reg    <= 1'b0;
      lock_id_reg <= 1'b0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else begin
      lock_reg    <= lock_next;
      lock_id_reg <= lock_id_next;
      count_reg   <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      id_mem[wr_ptr_reg] <= sel;
    end
  end

endmodule

// File: tb/tb_xcfi_mem_arbiter.sv
// Directed bench for xcfi_mem_arbiter; expectations follow XCFI_ARB_ROUND_ROBIN_EN when defined.
module tb_xcfi_mem_arbiter;

  localparam int XLEN = 32;

`ifdef XCFI_ARB_ROUND_ROBIN_EN
  localparam logic [1:0]      G_FIRST  = 2'b01;
  localparam logic [XLEN-1:0] A_FIRST  = 32'h0000_1000;
  localparam logic            W_FIRST  = 1'b0;
  localparam logic [3:0]      S_FIRST  = 4'h5;
  localparam logic [XLEN-1:0] D_FIRST  = 32'h1111_1111;
  localparam logic [1:0]      R_FIRST  = 2'b01;
  localparam logic [1:0]      G_REPEAT = 2'b01;
`else
  localparam logic [1:0]      G_FIRST  = 2'b10;
  localparam logic [XLEN-1:0] A_FIRST  = 32'h0000_2000;
  localparam logic            W_FIRST  = 1'b1;
  localparam logic [3:0]      S_FIRST  = 4'hA;
  localparam logic [XLEN-1:0] D_FIRST  = 32'h2222_2222;
  localparam logic [1:0]      R_FIRST  = 2'b10;
  localparam logic [1:0]      G_REPEAT = 2'b10;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        rq_req, rq_wen, rq_ack, rq_gnt, rq_recv;
  logic [7:0]        rq_strb;
  logic [2*XLEN-1:0] rq_wdata, rq_addr;
  logic              rq_error;
  logic [XLEN-1:0]   rq_rdata;
  logic              m_req, m_wen, m_gnt, m_recv, m_error, m_ack;
  logic [3:0]        m_strb;
  logic [XLEN-1:0]   m_wdata, m_addr, m_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  xcfi_mem_arbiter #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .rq_req(rq_req), .rq_wen(rq_wen), .rq_strb(rq_strb), .rq_wdata(rq_wdata),
    .rq_addr(rq_addr), .rq_gnt(rq_gnt), .rq_recv(rq_recv), .rq_ack(rq_ack),
    .rq_error(rq_error), .rq_rdata(rq_rdata),
    .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata), .m_addr(m_addr),
    .m_gnt(m_gnt), .m_recv(m_recv), .m_error(m_error), .m_rdata(m_rdata), .m_ack(m_ack)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rq_req = 2'b00; rq_wen = 2'b00; rq_ack = 2'b00; rq_strb = 8'h00;
    rq_wdata = '0; rq_addr = '0;
    m_gnt = 1'b0; m_recv = 1'b0; m_error = 1'b0; m_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    rq_req = 2'b11; m_gnt = 1'b1; m_recv = 1'b1; rq_ack = 2'b11;
    @(negedge clock);
    tests_run++; if (m_req !== 1'b0) begin tests_failed++; $display("FAIL reset_m_req got %b want 0", m_req); end
    tests_run++; if (rq_gnt !== 2'b00) begin tests_failed++; $display("FAIL reset_rq_gnt got %b want 00", rq_gnt); end
    tests_run++; if (rq_recv !== 2'b00) begin tests_failed++; $display("FAIL reset_rq_recv got %b want 00", rq_recv); end
    tests_run++; if (m_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_m_ack got %b want 0", m_ack); end
    tick();
    reset = 1'b0;
    rq_req = 2'b00; m_gnt = 1'b0;
    @(negedge clock);
    tests_run++; if (rq_recv !== 2'b00) begin tests_failed++; $display("FAIL reset_empty_recv got %b want 00", rq_recv); end
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_arbitration();
    do_reset();
    rq_req = 2'b11; m_gnt = 1'b1; rq_wen = 2'b10; rq_strb = 8'hA5;
    rq_addr = {32'h0000_2000, 32'h0000_1000};
    rq_wdata = {32'h2222_2222, 32'h1111_1111};
    @(negedge clock);
    tests_run++; if (rq_gnt !== G_FIRST) begin tests_failed++; $display("FAIL arb_gnt1 got %b want %b", rq_gnt, G_FIRST); end
    tests_run++; if (m_addr !== A_FIRST) begin tests_failed++; $display("FAIL arb_addr got %h want %h", m_addr, A_FIRST); end
    tests_run++; if (m_wen !== W_FIRST) begin tests_failed++; $display("FAIL arb_wen got %b want %b", m_wen, W_FIRST); end
    tests_run++; if (m_strb !== S_FIRST) begin tests_failed++; $display("FAIL arb_strb got %h want %h", m_strb, S_FIRST); end
    tests_run++; if (m_wdata !== D_FIRST) begin tests_failed++; $display("FAIL arb_wdata got %h want %h", m_wdata, D_FIRST); end
    tick();
    @(negedge clock);
    tests_run++; if (rq_gnt !== 2'b10) begin tests_failed++; $display("FAIL arb_gnt2 got %b want 10", rq_gnt); end
    tick();
    @(negedge clock);
    tests_run++; if (m_req !== 1'b0) begin tests_failed++; $display("FAIL arb_full_m_req got %b want 0", m_req); end
    tests_run++; if (rq_gnt !== 2'b00) begin tests_failed++; $display("FAIL arb_full_gnt got %b want 00", rq_gnt); end
    tick();
    rq_req = 2'b00; m_gnt = 1'b0; m_recv = 1'b1; rq_ack = 2'b11;
    @(negedge clock);
    tests_run++; if (rq_recv !== R_FIRST) begin tests_failed++; $display("FAIL arb_recv1 got %b want %b", rq_recv, R_FIRST); end
    tests_run++; if (m_ack !== 1'b1) begin tests_failed++; $display("FAIL arb_ack1 got %b want 1", m_ack); end
    tick();
    @(negedge clock);
    tests_run++; if (rq_recv !== 2'b10) begin tests_failed++; $display("FAIL arb_recv2 got %b want 10", rq_recv); end
    tick();
    m_recv = 1'b0; rq_req = 2'b11; m_gnt = 1'b1;
    @(negedge clock);
    tests_run++; if (rq_gnt !== G_REPEAT) begin tests_failed++; $display("FAIL arb_gnt3 got %b want %b", rq_gnt, G_REPEAT); end
    tick();
    idle();
    $display("[TB] test_arbitration done");
  endtask

  task automatic test_lock_and_full();
    do_reset();
    rq_req = 2'b01; m_gnt = 1'b0; rq_addr = {32'h0000_0200, 32'h0000_0100};
    @(negedge clock);
    tests_run++; if (m_req !== 1'b1) begin tests_failed++; $display("FAIL lock_m_req got %b want 1", m_req); end
    tests_run++; if (m_addr !== 32'h100) begin tests_failed++; $display("FAIL lock_addr_c1 got %h want 100", m_addr); end
    tests_run++; if (rq_gnt !== 2'b00) begin tests_failed++; $display("FAIL lock_gnt_c1 got %b want 00", rq_gnt); end
    tick();
    rq_req = 2'b11;
    @(negedge clock);
    tests_run++; if (m_addr !== 32'h100) begin tests_failed++; $display("FAIL lock_addr_c2 got %h want 100", m_addr); end
    tick();
    @(negedge clock);
    tests_run++; if (m_addr !== 32'h100) begin tests_failed++; $display("FAIL lock_addr_c3 got %h want 100", m_addr); end
    tick();
    m_gnt = 1'b1;
    @(negedge clock);
    tests_run++; if (rq_gnt !== 2'b01) begin tests_failed++; $display("FAIL lock_gnt_c4 got %b want 01", rq_gnt); end
    tests_run++; if (m_addr !== 32'h100) begin tests_failed++; $display("FAIL lock_addr_c4 got %h want 100", m_addr); end
    tick();
    rq_req = 2'b10;
    @(negedge clock);
    tests_run++; if (rq_gnt !== 2'b10) begin tests_failed++; $display("FAIL lock_gnt_c5 got %b want 10", rq_gnt); end
    tests_run++; if (m_addr !== 32'h200) begin tests_failed++; $display("FAIL lock_addr_c5 got %h want 200", m_addr); end
    tick();
    rq_req = 2'b11;
    @(negedge clock);
    tests_run++; if (m_req !== 1'b0) begin tests_failed++; $display("FAIL full_m_req got %b want 0", m_req); end
    tick();
    rq_req = 2'b00; m_gnt = 1'b0; m_recv = 1'b1; rq_ack = 2'b11; m_rdata = 32'hDEAD_BEEF; m_error = 1'b0;
    @(negedge clock);
    tests_run++; if (rq_recv !== 2'b01) begin tests_failed++; $display("FAIL resp1_recv got %b want 01", rq_recv); end
    tests_run++; if (rq_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL resp1_rdata got %h want deadbeef", rq_rdata); end
    tests_run++; if (rq_error !== 1'b0) begin tests_failed++; $display("FAIL resp1_error got %b want 0", rq_error); end
    tick();
    m_rdata = 32'hCAFE_F00D; m_error = 1'b1;
    @(negedge clock);
    tests_run++; if (rq_recv !== 2'b10) begin tests_failed++; $display("FAIL resp2_recv got %b want 10", rq_recv); end
    tests_run++; if (rq_rdata !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL resp2_rdata got %h want cafef00d", rq_rdata); end
    tests_run++; if (rq_error !== 1'b1) begin tests_failed++; $display("FAIL resp2_error got %b want 1", rq_error); end
    tick();
    @(negedge clock);
    tests_run++; if (rq_recv !== 2'b00) begin tests_failed++; $display("FAIL drained_recv got %b want 00", rq_recv); end
    tests_run++; if (m_ack !== 1'b0) begin tests_failed++; $display("FAIL drained_ack got %b want 0", m_ack); end
    tick();
    idle();
    $display("[TB] test_lock_and_full done");
  endtask

  task automatic test_withdrawal();
    do_reset();
    rq_req = 2'b01; m_gnt = 1'b0; rq_addr = {32'h0000_0200, 32'h0000_0100};
    tick();
    rq_req = 2'b10;
    @(negedge clock);
    tests_run++; if (m_req !== 1'b0) begin tests_failed++; $display("FAIL withdraw_m_req got %b want 0", m_req); end
    tick();
    @(negedge clock);
    tests_run++; if (m_req !== 1'b1) begin tests_failed++; $display("FAIL withdraw_next_req got %b want 1", m_req); end
    tests_run++; if (m_addr !== 32'h200) begin tests_failed++; $display("FAIL withdraw_addr got %h want 200", m_addr); end
    tick();
    idle();
    $display("[TB] test_withdrawal done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    rq_req = 2'b01; m_gnt = 1'b1;
    tick();
    rq_req = 2'b10; m_recv = 1'b1; rq_ack = 2'b01;
    @(negedge clock);
    tests_run++; if (rq_recv !== 2'b01) begin tests_failed++; $display("FAIL b2b_recv got %b want 01", rq_recv); end
    tests_run++; if (m_ack !== 1'b1) begin tests_failed++; $display("FAIL b2b_ack got %b want 1", m_ack); end
    tests_run++; if (rq_gnt !== 2'b10) begin tests_failed++; $display("FAIL b2b_gnt got %b want 10", rq_gnt); end
    tick();
    rq_req = 2'b01; m_gnt = 1'b0; m_recv = 1'b0;
    @(negedge clock);
    tests_run++; if (m_req !== 1'b1) begin tests_failed++; $display("FAIL b2b_count1_req got %b want 1", m_req); end
    tick();
    m_gnt = 1'b1;
    @(negedge clock);
    tests_run++; if (rq_gnt !== 2'b01) begin tests_failed++; $display("FAIL b2b_gnt2 got %b want 01", rq_gnt); end
    tick();
    m_recv = 1'b1; rq_ack = 2'b01;
    @(negedge clock);
    tests_run++; if (m_req !== 1'b0) begin tests_failed++; $display("FAIL b2b_full_req got %b want 0", m_req); end
    tests_run++; if (rq_recv !== 2'b10) begin tests_failed++; $display("FAIL b2b_head_recv got %b want 10", rq_recv); end
    tests_run++; if (m_ack !== 1'b0) begin tests_failed++; $display("FAIL b2b_head_ack got %b want 0", m_ack); end
    tick();
    rq_req = 2'b00; m_gnt = 1'b0; rq_ack = 2'b10;
    @(negedge clock);
    tests_run++; if (rq_recv !== 2'b10) begin tests_failed++; $display("FAIL b2b_pop_recv got %b want 10", rq_recv); end
    tests_run++; if (m_ack !== 1'b1) begin tests_failed++; $display("FAIL b2b_pop_ack got %b want 1", m_ack); end
    tick();
    rq_ack = 2'b11;
    @(negedge clock);
    tests_run++; if (rq_recv !== 2'b01) begin tests_failed++; $display("FAIL b2b_last_recv got %b want 01", rq_recv); end
    tick();
    idle();
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_empty_and_reset();
    do_reset();
    m_recv = 1'b1; rq_ack = 2'b11;
    @(negedge clock);
    tests_run++; if (m_ack !== 1'b0) begin tests_failed++; $display("FAIL empty_ack got %b want 0", m_ack); end
    tests_run++; if (rq_recv !== 2'b00) begin tests_failed++; $display("FAIL empty_recv got %b want 00", rq_recv); end
    tick();
    m_recv = 1'b0; rq_req = 2'b11; m_gnt = 1'b1;
    tick();
    tick();
    reset = 1'b1; rq_req = 2'b00; m_gnt = 1'b0;
    tick();
    reset = 1'b0;
    m_recv = 1'b1; rq_ack = 2'b11; rq_req = 2'b01; m_gnt = 1'b1;
    @(negedge clock);
    tests_run++; if (rq_recv !== 2'b00) begin tests_failed++; $display("FAIL postrst_recv got %b want 00", rq_recv); end
    tests_run++; if (m_ack !== 1'b0) begin tests_failed++; $display("FAIL postrst_ack got %b want 0", m_ack); end
    tests_run++; if (m_req !== 1'b1) begin tests_failed++; $display("FAIL postrst_m_req got %b want 1", m_req); end
    tick();
    idle();
    $display("[TB] test_empty_and_reset done");
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_lock_and_full();
    test_withdrawal();
    test_back_to_back();
    test_empty_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/xcfi_mem_arbiter.md
XCFI_MEM_ARBITER -- requirements
Module: xcfi_mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH, default 2, max outstanding accepted-but-unresponded transactions (power of two, >=2).
REQ-003 SHALL have port clock  input  1  the single clock for all state.
REQ-004 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port rq_req  input  2  request per requester; bit0 = imem, bit1 = dmem.
REQ-006 SHALL have port rq_wen  input  2  write enable per requester.
REQ-007 SHALL have port rq_strb  input  8  write strobes, [4n+3:4n] for requester n.
REQ-008 SHALL have port rq_wdata  input  2*XLEN  write data, slice n for requester n.
REQ-009 SHALL have port rq_addr  input  2*XLEN  address, slice n for requester n.
REQ-010 SHALL have port rq_gnt  output  2  request accepted, per requester.
REQ-011 SHALL have port rq_recv  output  2  response valid, per requester.
REQ-012 SHALL have port rq_ack  input  2  requester accepts response.
REQ-013 SHALL have port rq_error  output  1  response error, broadcast.
REQ-014 SHALL have port rq_rdata  output  XLEN  response read data, broadcast.
REQ-015 SHALL have ports m_req, m_wen (output 1), m_strb (output 4), m_wdata, m_addr (output XLEN): shared memory request side.
REQ-016 SHALL have ports m_gnt, m_recv, m_error (input 1), m_rdata (input XLEN), m_ack (output 1): shared memory handshake/response side.

Function
REQ-017 Request transfer SHALL occur on a cycle with m_req & m_gnt; response transfer on a cycle with m_recv & m_ack.
REQ-018 Selected requester sel SHALL be the locked id if lock is set, else the arbitration winner among asserted rq_req bits.
REQ-019 Arbitration winner SHALL be dmem (bit1) over imem (bit0) when both request (fixed priority, see REQ-031).
REQ-020 m_req SHALL equal rq_req[sel] & !full; m_wen/m_strb/m_wdata/m_addr SHALL be combinationally muxed from sel (zero latency).
REQ-021 rq_gnt[sel] SHALL equal m_req & m_gnt; the other rq_gnt bit SHALL be 0.
REQ-022 If m_req & !m_gnt, lock SHALL set with lock id = sel next cycle and hold until the cycle m_gnt accepts it; lock SHALL clear if rq_req[lock id] drops (requester withdrawal).
REQ-023 On each request transfer sel SHALL be pushed into an in-order id FIFO of DEPTH entries; full = (count == DEPTH), with no same-cycle pop bypass.
REQ-024 rq_recv[head] SHALL equal m_recv and m_ack SHALL equal rq_ack[head] when FIFO non-empty; other rq_recv bit 0.
REQ-025 FIFO empty: rq_recv = 2'b00, m_ack = 0; any m_recv is ignored (not acked).
REQ-026 Response transfer SHALL pop the FIFO; simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 rq_rdata = m_rdata, rq_error = m_error at all times (broadcast, qualified by rq_recv).

Reset
REQ-028 While reset is high, m_req, rq_gnt, rq_recv, m_ack SHALL be 0; at the next edge, FIFO count, pointers, lock and round-robin pointer SHALL clear.
REQ-029 Reset mid-transaction SHALL discard all outstanding ids; responses arriving after reset with an empty FIFO follow REQ-025.

Configuration
REQ-030 Macro XCFI_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-031 Defined: when both request, the winner SHALL be the requester not granted on the last request transfer (last-grant register, reset value dmem so imem wins first); undefined: fixed priority per REQ-019, no last-grant register.

Verification
REQ-032 Both rq_req high, m_gnt=1 each cycle, macro undefined -> rq_gnt=2'b10 every cycle until FIFO full; macro defined -> grants alternate 01,10,01.
REQ-033 imem req with addr 0x100, m_gnt low 3 cycles, dmem req asserted cycle 2 -> m_addr stays 0x100, grant goes to imem on cycle 4, dmem next.
REQ-034 Two accepts (imem then dmem), no responses -> m_req=0 while full; m_recv with m_rdata 0xDEADBEEF -> rq_recv=01, then next response rq_recv=10.
REQ-035 FIFO holding 1 entry, push and pop same cycle -> count stays 1, head advances to the new id.
REQ-036 m_recv=1 with FIFO empty -> m_ack=0, rq_recv=00; reset asserted with 2 outstanding -> after reset count=0, rq_recv=00 for any m_recv.
